// File: rtl/rename_unit_pkg.sv
// Shared types for the Qu register-rename stage. uop_t register fields are sized
// for the largest supported physical file; smaller configurations zero-extend.
package qu_rename;

  localparam int QU_LOG_RF_DEPTH = 32;
  localparam int QU_PHY_RF_DEPTH = 128;
  localparam int QU_LOG_ADDR_W   = $clog2(QU_LOG_RF_DEPTH);
  localparam int QU_PHY_ADDR_W   = $clog2(QU_PHY_RF_DEPTH);
  localparam int QU_PAYLOAD_W    = 16;

  typedef logic [QU_PHY_ADDR_W-1:0] phy_addr_t;
  typedef logic [QU_LOG_ADDR_W-1:0] log_addr_t;

  localparam phy_addr_t PHY_ZERO = '0;

  typedef struct packed {
    logic [QU_PAYLOAD_W-1:0] payload;
    logic                    rd_valid;
    logic                    rs1_valid;
    logic                    rs2_valid;
    phy_addr_t               rd;
    phy_addr_t               rs1;
    phy_addr_t               rs2;
  } uop_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers with a speculative allocation head,
// a committed head, a tail fed by commits, and single-cycle flush restore.
module rename_free_list
  import qu_rename::*;
#(
  parameter int  LOG_RF_DEPTH      = QU_LOG_RF_DEPTH,
  parameter int  PHY_RF_DEPTH      = QU_PHY_RF_DEPTH,
  localparam int FL_DEPTH          = PHY_RF_DEPTH - LOG_RF_DEPTH,
  localparam int PTR_W             = $clog2(FL_DEPTH),
  localparam int CNT_W             = $clog2(FL_DEPTH + 1),
  localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] alloc_pd,
  input  logic                         commit_en,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] commit_pd_old,
  input  logic                         flush,
  output logic [CNT_W-1:0]             free_count
);

  typedef logic [PTR_W-1:0]             ptr_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0] pd_t;
  typedef logic [CNT_W-1:0]             cnt_t;

  localparam ptr_t PTR_LAST = ptr_t'(FL_DEPTH - 1);
  localparam cnt_t CNT_FULL = cnt_t'(FL_DEPTH);

  // Compare-and-reset keeps non-power-of-two depths wrapping correctly.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
  endfunction

  pd_t  fl_q [FL_DEPTH];
  pd_t  fl_d [FL_DEPTH];
  ptr_t spec_head_q, spec_head_d;
  ptr_t commit_head_q, commit_head_d;
  ptr_t tail_q, tail_d;
  cnt_t free_count_q, free_count_d;
  cnt_t used;

  always_comb begin
    fl_d          = fl_q;
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    free_count_d  = free_count_q;
    used          = '0;
    if (commit_en) begin
      fl_d[tail_q]  = commit_pd_old;
      tail_d        = ptr_inc(tail_q);
      commit_head_d = ptr_inc(commit_head_q);
    end
    if (flush) begin
      // Restore to the committed view, including this cycle's commit.
      spec_head_d = commit_head_d;
      if (tail_d >= commit_head_d)
        used = cnt_t'(tail_d) - cnt_t'(commit_head_d);
      else
        used = CNT_FULL - (cnt_t'(commit_head_d) - cnt_t'(tail_d));
      free_count_d = CNT_FULL - used;
    end else begin
      if (alloc_en)
        spec_head_d = ptr_inc(spec_head_q);
      free_count_d = free_count_q + cnt_t'(commit_en) - cnt_t'(alloc_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fl_q[i] <= pd_t'(LOG_RF_DEPTH + i);
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      free_count_q  <= CNT_FULL;
    end else begin
      fl_q          <= fl_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_count_q  <= free_count_d;
    end
  end

  assign alloc_pd   = fl_q[spec_head_q];
  assign free_count = free_count_q;

  // A commit with nothing in flight would push the tail past the committed head.
  a_no_tail_overrun: assert property (@(posedge clk) disable iff (!rst_n)
    !(commit_en && !alloc_en && free_count_q == CNT_FULL));

endmodule

// File: rtl/rename_unit.sv
// Register-rename stage: speculative and committed RATs, valid/ready handshake,
// one-deep output register, commit-driven freeing and single-cycle flush.
module rename_unit
  import qu_rename::*;
#(
  parameter int  LOG_RF_DEPTH      = QU_LOG_RF_DEPTH,
  parameter int  PHY_RF_DEPTH      = QU_PHY_RF_DEPTH,
  localparam int FL_DEPTH          = PHY_RF_DEPTH - LOG_RF_DEPTH,
  localparam int LOG_RF_ADDR_WIDTH = $clog2(LOG_RF_DEPTH),
  localparam int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH),
  localparam int CNT_W             = $clog2(FL_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  uop_t                         uop_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output uop_t                         uop_out,
  output logic [PHY_RF_ADDR_WIDTH-1:0] pd_old,
  input  logic                         commit_en,
  input  logic [LOG_RF_ADDR_WIDTH-1:0] commit_rd,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] commit_pd,
  input  logic [PHY_RF_ADDR_WIDTH-1:0] commit_pd_old,
  input  logic                         flush,
  output logic                         busy_table_wr_en,
  output logic [PHY_RF_ADDR_WIDTH-1:0] busy_table_wr_addr,
  output logic                         busy_table_data_out
);

  typedef logic [PHY_RF_ADDR_WIDTH-1:0] pd_t;
  typedef logic [LOG_RF_ADDR_WIDTH-1:0] lr_t;

  pd_t  spec_rat_q   [LOG_RF_DEPTH];
  pd_t  spec_rat_d   [LOG_RF_DEPTH];
  pd_t  commit_rat_q [LOG_RF_DEPTH];
  pd_t  commit_rat_d [LOG_RF_DEPTH];
  logic out_valid_q, out_valid_d;
  uop_t uop_q, uop_d;
  pd_t  pd_old_q, pd_old_d;

  logic             accept;
  logic             alloc_en;
  logic             commit_valid;
  pd_t              alloc_pd;
  logic [CNT_W-1:0] free_count;
  lr_t              rd_log, rs1_log, rs2_log;

  assign rd_log  = lr_t'(uop_in.rd);
  assign rs1_log = lr_t'(uop_in.rs1);
  assign rs2_log = lr_t'(uop_in.rs2);

  assign in_ready     = rst_n && !flush && (!out_valid_q || out_ready) && (free_count != '0);
  assign accept       = in_valid && in_ready;
  assign alloc_en     = accept && uop_in.rd_valid && (uop_in.rd != PHY_ZERO);
  assign commit_valid = commit_en && (commit_rd != '0);

  rename_free_list #(
    .LOG_RF_DEPTH (LOG_RF_DEPTH),
    .PHY_RF_DEPTH (PHY_RF_DEPTH)
  ) u_free_list (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_en      (alloc_en),
    .alloc_pd      (alloc_pd),
    .commit_en     (commit_valid),
    .commit_pd_old (commit_pd_old),
    .flush         (flush),
    .free_count    (free_count)
  );

  always_comb begin
    spec_rat_d   = spec_rat_q;
    commit_rat_d = commit_rat_q;
    out_valid_d  = out_valid_q;
    uop_d        = uop_q;
    pd_old_d     = pd_old_q;
    if (commit_valid)
      commit_rat_d[commit_rd] = commit_pd;
    if (flush) begin
      spec_rat_d  = commit_rat_d;
      out_valid_d = 1'b0;
    end else if (accept) begin
      // Sources read the pre-update map, so rs == rd sees the old mapping.
      uop_d = uop_in;
      if (uop_in.rs1_valid)
        uop_d.rs1 = phy_addr_t'(spec_rat_q[rs1_log]);
      if (uop_in.rs2_valid)
        uop_d.rs2 = phy_addr_t'(spec_rat_q[rs2_log]);
      uop_d.rd = PHY_ZERO;
      pd_old_d = '0;
      if (alloc_en) begin
        uop_d.rd           = phy_addr_t'(alloc_pd);
        pd_old_d           = spec_rat_q[rd_log];
        spec_rat_d[rd_log] = alloc_pd;
      end
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LOG_RF_DEPTH; i++) begin
        spec_rat_q[i]   <= pd_t'(i);
        commit_rat_q[i] <= pd_t'(i);
      end
      out_valid_q <= 1'b0;
      uop_q       <= '0;
      pd_old_q    <= '0;
    end else begin
      spec_rat_q   <= spec_rat_d;
      commit_rat_q <= commit_rat_d;
      out_valid_q  <= out_valid_d;
      uop_q        <= uop_d;
      pd_old_q     <= pd_old_d;
    end
  end

  assign out_valid           = out_valid_q;
  assign uop_out             = uop_q;
  assign pd_old              = pd_old_q;
  assign busy_table_wr_en    = alloc_en;
  assign busy_table_wr_addr  = alloc_en ? alloc_pd : '0;
  assign busy_table_data_out = 1'b1;

endmodule

// File: tb/tb_rename_unit.sv
// Randomized bench for rename_unit (LOG=32, PHY=64) against a queue-based
// model of the free list, in-flight allocations and both alias tables.
module tb_rename_unit;
  import qu_rename::*;

  localparam int LOG = 32;
  localparam int PHY = 64;
  localparam int FL  = PHY - LOG;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_ready, out_valid, out_ready;
  logic       commit_en, flush, busy_en, busy_data;
  uop_t       uop_in, uop_out;
  logic [5:0] pd_old, commit_pd, commit_pd_old, busy_addr;
  logic [4:0] commit_rd;

  always #5 clk = ~clk;

  rename_unit #(.LOG_RF_DEPTH(LOG), .PHY_RF_DEPTH(PHY)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .uop_in              (uop_in),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .uop_out             (uop_out),
    .pd_old              (pd_old),
    .commit_en           (commit_en),
    .commit_rd           (commit_rd),
    .commit_pd           (commit_pd),
    .commit_pd_old       (commit_pd_old),
    .flush               (flush),
    .busy_table_wr_en    (busy_en),
    .busy_table_wr_addr  (busy_addr),
    .busy_table_data_out (busy_data)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: plain tables and queues, program-order in-flight list.
  typedef struct {
    int rd;
    int pd;
    int pd_old;
  } inflight_t;

  int        spec_rat   [LOG];
  int        commit_rat [LOG];
  int        free_q     [$];
  inflight_t inflight   [$];
  bit        m_out_valid;
  uop_t      m_uop;
  int        m_pd_old;

  function automatic void model_reset();
    for (int i = 0; i < LOG; i++) begin
      spec_rat[i]   = i;
      commit_rat[i] = i;
    end
    free_q.delete();
    for (int i = 0; i < FL; i++) free_q.push_back(LOG + i);
    inflight.delete();
    m_out_valid = 1'b0;
    m_uop       = '0;
    m_pd_old    = 0;
  endfunction

  task automatic run_cycle(input int commit_pct, input int flush_pct, input int ready_pct,
                           input bit do_reset);
    uop_t      u, exp_u;
    bit        exp_ready, acc, alloc, cmt_pick, cmt_valid;
    int        lrd, pd, pdo;
    inflight_t f;

    u           = '0;
    u.payload   = 16'($urandom);
    u.rd_valid  = ($urandom_range(0, 99) < 85);
    u.rs1_valid = ($urandom_range(0, 99) < 80);
    u.rs2_valid = ($urandom_range(0, 99) < 80);
    u.rd  = u.rd_valid  ? phy_addr_t'($urandom_range(0, LOG - 1)) : phy_addr_t'($urandom);
    if ($urandom_range(0, 9) == 0) u.rd = '0;
    u.rs1 = u.rs1_valid ? phy_addr_t'($urandom_range(0, LOG - 1)) : phy_addr_t'($urandom);
    u.rs2 = u.rs2_valid ? phy_addr_t'($urandom_range(0, LOG - 1)) : phy_addr_t'($urandom);
    uop_in        = u;
    in_valid      = ($urandom_range(0, 99) < 80);
    out_ready     = ($urandom_range(0, 99) < ready_pct);
    flush         = ($urandom_range(0, 99) < flush_pct);
    rst_n         = !do_reset;
    commit_en     = 1'b0;
    commit_rd     = '0;
    commit_pd     = 6'($urandom);
    commit_pd_old = 6'($urandom);
    cmt_pick      = ($urandom_range(0, 99) < commit_pct);
    if (do_reset) begin
      commit_en = 1'b1;
      commit_rd = 5'($urandom);
    end else if (cmt_pick && $urandom_range(0, 9) == 0) begin
      commit_en = 1'b1;
    end else if (cmt_pick && inflight.size() != 0) begin
      commit_en     = 1'b1;
      commit_rd     = 5'(inflight[0].rd);
      commit_pd     = 6'(inflight[0].pd);
      commit_pd_old = 6'(inflight[0].pd_old);
    end
    #1;

    cmt_valid = rst_n && commit_en && (commit_rd != '0);
    exp_ready = rst_n && !flush && (!m_out_valid || out_ready) && (free_q.size() != 0);
    acc       = in_valid && exp_ready;
    alloc     = acc && u.rd_valid && (u.rd != '0);

    check_eq("out_valid", 64'(out_valid), 64'(m_out_valid));
    if (m_out_valid) begin
      check_eq("uop_out", 64'(uop_out), 64'(m_uop));
      check_eq("pd_old", 64'(pd_old), 64'(m_pd_old));
    end
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    check_eq("busy_wr_en", 64'(busy_en), 64'(alloc));
    check_eq("busy_data", 64'(busy_data), 64'(1));

    if (!rst_n) begin
      model_reset();
      $display("[TB] cyc %0d reset", cyc);
    end else begin
      if (acc) begin
        exp_u = u;
        if (u.rs1_valid) exp_u.rs1 = phy_addr_t'(spec_rat[int'(u.rs1)]);
        if (u.rs2_valid) exp_u.rs2 = phy_addr_t'(spec_rat[int'(u.rs2)]);
        exp_u.rd = '0;
        pd       = 0;
        pdo      = 0;
        if (alloc) begin
          lrd = int'(u.rd);
          pd  = free_q.pop_front();
          pdo = spec_rat[lrd];
          check_eq("busy_addr", 64'(busy_addr), 64'(pd));
          spec_rat[lrd] = pd;
          exp_u.rd      = phy_addr_t'(pd);
          inflight.push_back('{lrd, pd, pdo});
        end
        m_uop       = exp_u;
        m_pd_old    = pdo;
        m_out_valid = 1'b1;
        $display("[TB] cyc %0d accept rd_valid=%0d rd=%0d -> p%0d pd_old=p%0d free=%0d",
                 cyc, u.rd_valid, u.rd, pd, pdo, free_q.size());
      end else if (out_ready) begin
        m_out_valid = 1'b0;
      end
      if (cmt_valid) begin
        f = inflight.pop_front();
        commit_rat[f.rd] = f.pd;
        free_q.push_back(f.pd_old);
      end
      if (flush) begin
        spec_rat = commit_rat;
        for (int i = inflight.size() - 1; i >= 0; i--) free_q.push_front(inflight[i].pd);
        inflight.delete();
        m_out_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    uop_in        = '0;
    out_ready     = 1'b0;
    commit_en     = 1'b0;
    commit_rd     = '0;
    commit_pd     = '0;
    commit_pd_old = '0;
    flush         = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_busy_en", 64'(busy_en), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Drain the free list with no commits, then mixed traffic, backpressure,
    // a mid-run reset and a flush-heavy tail.
    for (int c = 0; c < 80; c++)  run_cycle(0, 0, 100, 1'b0);
    for (int c = 0; c < 300; c++) run_cycle(50, 3, 70, 1'b0);
    for (int c = 0; c < 100; c++) run_cycle(25, 0, 25, 1'b0);
    run_cycle(50, 0, 50, 1'b1);
    for (int c = 0; c < 300; c++) run_cycle(70, 5, 90, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
